// File: rtl/cache_way_ctrl.sv
// Tag/valid/LRU controller for a 2-way, 8-set cache with block refill.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_way_ctrl #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = ADDR_W - 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [2:0]        index,
   output logic [1:0]        write,
   output logic [1:0]        WF,
   output logic [255:0]      inblock,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [255:0]      mem_data
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      FILL,
      RESP
   } state_e;

   state_e state_q, state_d;

   logic [TAG_W-1:0] rtag_q, rtag_d;
   logic [2:0]       ridx_q, ridx_d;
   logic             way_q, way_d;
   logic             hit_q, hit_d;

   logic [TAG_W-1:0] tag_q [2][8];
   logic [1:0][7:0]  valid_q, valid_d;
   logic [7:0]       lru_q, lru_d;

   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_hit_q, resp_hit_d;
   logic [2:0]        index_q, index_d;
   logic [1:0]        write_q, write_d;
   logic [1:0]        wf_q, wf_d;
   logic [255:0]      inblock_q, inblock_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic match0, match1, victim;

   // Offset bits never reach the controller state.
   logic unused_offset;
   assign unused_offset = ^req_addr[4:0];

   always_comb begin
      match0 = valid_q[0][ridx_q] && (tag_q[0][ridx_q] == rtag_q);
      match1 = valid_q[1][ridx_q] && (tag_q[1][ridx_q] == rtag_q);
      if (!valid_q[0][ridx_q])
         victim = 1'b0;
      else if (!valid_q[1][ridx_q])
         victim = 1'b1;
      else
         victim = lru_q[ridx_q];
   end

   always_comb begin
      state_d   = state_q;
      rtag_d    = rtag_q;
      ridx_d    = ridx_q;
      way_d     = way_q;
      hit_d     = hit_q;
      valid_d   = valid_q;
      lru_d     = lru_q;
      inblock_d = inblock_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               rtag_d  = req_addr[ADDR_W-1:8];
               ridx_d  = req_addr[7:5];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (match0 || match1) begin
               // Way 0 takes priority if both ways somehow match.
               way_d         = ~match0;
               hit_d         = 1'b1;
               lru_d[ridx_q] = match0;
               state_d       = RESP;
            end else begin
               way_d   = victim;
               hit_d   = 1'b0;
               state_d = MISS;
            end
         end
         MISS: begin
            if (mem_ack) begin
               inblock_d = mem_data;
               state_d   = FILL;
            end
         end
         FILL: begin
            valid_d[way_q][ridx_q] = 1'b1;
            lru_d[ridx_q]          = ~way_q;
            state_d                = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so derive them from the next state.
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      resp_hit_d   = (state_d == RESP) && hit_d;
      index_d      = (state_d != IDLE) ? ridx_d : index_q;
      write_d      = (state_d == FILL) ? {way_d, ~way_d} : 2'b00;
      wf_d         = (state_d == RESP) ? {way_d, ~way_d} : 2'b00;
      mem_req_d    = (state_d == MISS);
      mem_addr_d   = (state_d == MISS) ? {rtag_d, ridx_d, 5'b0}
                                       : mem_addr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rtag_q       <= '0;
         ridx_q       <= '0;
         way_q        <= 1'b0;
         hit_q        <= 1'b0;
         valid_q      <= '0;
         lru_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         index_q      <= '0;
         write_q      <= '0;
         wf_q         <= '0;
         inblock_q    <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         rtag_q       <= rtag_d;
         ridx_q       <= ridx_d;
         way_q        <= way_d;
         hit_q        <= hit_d;
         valid_q      <= valid_d;
         lru_q        <= lru_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         index_q      <= index_d;
         write_q      <= write_d;
         wf_q         <= wf_d;
         inblock_q    <= inblock_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   // Tags are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (!rst && state_q == FILL)
         tag_q[way_q][ridx_q] <= rtag_q;
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign index      = index_q;
   assign write      = write_q;
   assign WF         = wf_q;
   assign inblock    = inblock_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == RESP) begin
         if (resp_hit_q && hit_cnt_q != 16'hFFFF)
            hit_cnt_d = hit_cnt_q + 16'd1;
         if (!resp_hit_q && miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl: hit/miss paths, LRU victims,
// ignored acks, reset mid-refill and optional statistics counters.
module tb_cache_way_ctrl;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic [31:0]  req_addr;
   logic         req_ready;
   logic         resp_valid;
   logic         resp_hit;
   logic [2:0]   index;
   logic [1:0]   write;
   logic [1:0]   WF;
   logic [255:0] inblock;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack;
   logic [255:0] mem_data;
`ifdef CACHE_STATS_EN
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   cache_way_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_hit   (resp_hit),
      .index      (index),
      .write      (write),
      .WF         (WF),
      .inblock    (inblock),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts and ends at a falling edge in an IDLE cycle.
   task automatic rd(input logic [31:0] a,
                     input bit exp_hit,
                     input bit exp_way,
                     input int n,
                     input logic [255:0] pat);
      logic [1:0]  oh;
      logic [2:0]  ix;
      logic [31:0] ba;
      oh = exp_way ? 2'b10 : 2'b01;
      ix = a[7:5];
      ba = {a[31:5], 5'b0};
      check("ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      req_valid = 1'b0;
      check("lk_rv", resp_valid, 1'b0);
      check("lk_index", index, ix);
      check("lk_ready", req_ready, 1'b0);
      @(negedge clk);
      if (exp_hit) begin
         check("hit_rv", resp_valid, 1'b1);
         check("hit_flag", resp_hit, 1'b1);
         check("hit_wf", WF, oh);
         check("hit_memreq", mem_req, 1'b0);
         check("hit_write", write, 2'b00);
      end else begin
         check("miss_rv", resp_valid, 1'b0);
         check("miss_memreq", mem_req, 1'b1);
         check("miss_addr", mem_addr, ba);
         for (int k = 1; k < n; k++) begin
            @(negedge clk);
            check("miss_hold_req", mem_req, 1'b1);
            check("miss_hold_addr", mem_addr, ba);
         end
         mem_ack  = 1'b1;
         mem_data = pat;
         @(negedge clk);
         mem_ack  = 1'b0;
         mem_data = '0;
         check("fill_write", write, oh);
         check("fill_wf", WF, 2'b00);
         check("fill_index", index, ix);
         check("fill_data", inblock, pat);
         check("fill_memreq", mem_req, 1'b0);
         check("fill_rv", resp_valid, 1'b0);
         @(negedge clk);
         check("mresp_rv", resp_valid, 1'b1);
         check("mresp_hit", resp_hit, 1'b0);
         check("mresp_wf", WF, oh);
         check("mresp_write", write, 2'b00);
      end
      @(negedge clk);
      check("idle_rv", resp_valid, 1'b0);
      check("idle_wf", WF, 2'b00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   logic [255:0] pat_a, pat_b, pat_c, pat_d;

   initial begin
      pat_a     = {8{32'hA5A5_0001}};
      pat_b     = {8{32'h5A5A_0002}};
      pat_c     = {8{32'hC3C3_0003}};
      pat_d     = {8{32'h3C3C_0004}};
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      mem_ack   = 1'b0;
      mem_data  = '0;
      @(negedge clk);
      check("rst_ready", req_ready, 1'b1);
      check("rst_rv", resp_valid, 1'b0);
      check("rst_hit", resp_hit, 1'b0);
      check("rst_memreq", mem_req, 1'b0);
      check("rst_write", write, 2'b00);
      check("rst_wf", WF, 2'b00);
      check("rst_index", index, 3'd0);
      check("rst_memaddr", mem_addr, 32'd0);
      check("rst_inblock", inblock, 256'd0);
      rst = 1'b0;
      @(negedge clk);

      rd(32'h0000_0120, 1'b0, 1'b0, 3, pat_a);
      rd(32'h0000_013C, 1'b1, 1'b0, 0, '0);
      rd(32'h0000_1120, 1'b0, 1'b1, 1, pat_b);
      rd(32'h0000_2120, 1'b0, 1'b0, 2, pat_c);
      rd(32'h0000_1120, 1'b1, 1'b1, 0, '0);
      rd(32'h0000_3120, 1'b0, 1'b0, 1, pat_d);
      rd(32'h0000_1120, 1'b1, 1'b1, 0, '0);
      rd(32'h0000_3120, 1'b1, 1'b0, 0, '0);

      // An ack while idle must change nothing.
      mem_ack  = 1'b1;
      mem_data = pat_a;
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_data = '0;
      check("ign_ready", req_ready, 1'b1);
      check("ign_rv", resp_valid, 1'b0);
      check("ign_write", write, 2'b00);
      check("ign_inblock", inblock, pat_d);
      @(negedge clk);

      rd(32'h0000_0040, 1'b0, 1'b0, 2, pat_b);
      rd(32'h0000_0040, 1'b1, 1'b0, 0, '0);

      // Reset while the refill is outstanding.
      req_valid = 1'b1;
      req_addr  = 32'h0000_8060;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("ab_memreq", mem_req, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("ab_drop", mem_req, 1'b0);
      check("ab_ready", req_ready, 1'b1);
      check("ab_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(32'h0000_8060, 1'b0, 1'b0, 2, pat_c);
      rd(32'h0000_0120, 1'b0, 1'b0, 1, pat_a);

      do_reset();
      rd(32'h0000_0120, 1'b0, 1'b0, 1, pat_a);
      rd(32'h0000_1120, 1'b0, 1'b1, 1, pat_b);
      rd(32'h0000_0040, 1'b0, 1'b0, 1, pat_c);
      rd(32'h0000_0120, 1'b1, 1'b0, 0, '0);
      rd(32'h0000_0120, 1'b1, 1'b0, 0, '0);
      rd(32'h0000_0120, 1'b1, 1'b0, 0, '0);
      rd(32'h0000_1120, 1'b1, 1'b1, 0, '0);
      rd(32'h0000_0040, 1'b1, 1'b0, 0, '0);
`ifdef CACHE_STATS_EN
      check("stat_miss", miss_cnt, 16'd3);
      check("stat_hit", hit_cnt, 16'd5);
      force dut.hit_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.hit_cnt_q;
      @(negedge clk);
      rd(32'h0000_0040, 1'b1, 1'b0, 0, '0);
      check("stat_sat", hit_cnt, 16'hFFFF);
      check("stat_miss2", miss_cnt, 16'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
